// File: rtl/ap_hs_initiator_if.sv
// ap_ctrl_hs register-access bus between the host-side initiator (master) and the DUFT responder (slave).
interface ap_hs_initiator_if;
    logic        ap_start;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        rd_wr;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;
    logic [31:0] ap_return;

    modport master (
        output ap_start, addr, wr_data, rd_wr,
        input  ap_idle, ap_ready, ap_done, ap_return
    );

    modport slave (
        input  ap_start, addr, wr_data, rd_wr,
        output ap_idle, ap_ready, ap_done, ap_return
    );
endinterface

// File: rtl/ap_hs_initiator.sv
// Host-side ap_ctrl_hs initiator: one read/write command in flight, one response carrying data or a timeout flag.
// Defining AP_HS_INITIATOR_STATS_EN adds saturating read/write/timeout counters with a synchronous clear.
module ap_hs_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rd_wr,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_is_rd,
    output logic             rsp_timeout,
`ifdef AP_HS_INITIATOR_STATS_EN
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_rd_cnt,
    output logic [CNT_W-1:0] stat_wr_cnt,
    output logic [CNT_W-1:0] stat_to_cnt,
`endif
    ap_hs_initiator_if.master ap
);
    // state  | meaning
    // S_IDLE | ready for a command
    // S_ARM  | command latched, waiting for the responder to show idle
    // S_BUSY | ap_start high, waiting for ap_done
    // S_RESP | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_BUSY, S_RESP} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
    localparam logic [TW-1:0] TC_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state, state_nx;
    logic [TW-1:0]   tcnt, tcnt_d;
    logic            accept, done_hit, to_hit;
    logic            cmd_ready_d, rsp_valid_d, rsp_is_rd_d, rsp_timeout_d;
    logic            ap_start_d, rd_wr_d;
    logic [31:0]     rsp_rdata_d, addr_d, wr_data_d;
    logic            unused_sink;

    assign accept   = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign done_hit = (state == S_BUSY) && ap.ap_done;
    assign to_hit   = (TIMEOUT_CYCLES > 0) && (tcnt == TC_LAST);

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_is_rd   <= 1'b0;
            rsp_timeout <= 1'b0;
            ap.ap_start <= 1'b0;
            ap.addr     <= '0;
            ap.wr_data  <= '0;
            ap.rd_wr    <= 1'b0;
        end else begin
            state       <= state_nx;
            tcnt        <= tcnt_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_is_rd   <= rsp_is_rd_d;
            rsp_timeout <= rsp_timeout_d;
            ap.ap_start <= ap_start_d;
            ap.addr     <= addr_d;
            ap.wr_data  <= wr_data_d;
            ap.rd_wr    <= rd_wr_d;
        end
    end

    // A timeout in S_ARM aborts even if the responder just went idle; in S_BUSY ap_done beats it.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_ARM;
            S_ARM: begin
                if (to_hit)          state_nx = S_RESP;
                else if (ap.ap_idle) state_nx = S_BUSY;
            end
            S_BUSY: if (done_hit || to_hit) state_nx = S_RESP;
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d   = cmd_ready;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_is_rd_d   = rsp_is_rd;
        rsp_timeout_d = rsp_timeout;
        ap_start_d    = ap.ap_start;
        addr_d        = ap.addr;
        wr_data_d     = ap.wr_data;
        rd_wr_d       = ap.rd_wr;
        tcnt_d        = tcnt;
        case (state)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    rd_wr_d     = cmd_rd_wr;
                    addr_d      = cmd_addr;
                    wr_data_d   = cmd_wdata;
                    tcnt_d      = '0;
                end
            end
            S_ARM, S_BUSY: begin
                tcnt_d = tcnt + 1'b1;
                if (done_hit) begin
                    ap_start_d    = 1'b0;
                    rsp_rdata_d   = ap.rd_wr ? ap.ap_return : 32'h0;
                    rsp_is_rd_d   = ap.rd_wr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                end else if (to_hit) begin
                    ap_start_d    = 1'b0;
                    rsp_rdata_d   = 32'h0;
                    rsp_is_rd_d   = ap.rd_wr;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                end else if (state == S_ARM && ap.ap_idle) begin
                    ap_start_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef AP_HS_INITIATOR_STATS_EN
    logic fin;
    assign fin         = (state == S_ARM || state == S_BUSY) && (state_nx == S_RESP);
    assign unused_sink = ap.ap_ready;

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            stat_to_cnt <= '0;
        end else if (stat_clr) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            stat_to_cnt <= '0;
        end else if (fin) begin
            if (!done_hit) begin
                if (stat_to_cnt != '1) stat_to_cnt <= stat_to_cnt + 1'b1;
            end else if (ap.rd_wr) begin
                if (stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 1'b1;
            end else begin
                if (stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 1'b1;
            end
        end
    end
`else
    assign unused_sink = ap.ap_ready | (CNT_W < 1);
`endif
endmodule

// File: tb/tb_ap_hs_initiator.sv
// Bench for ap_hs_initiator: behavioural DUFT responder plus a shadow register map as the reference model.
`timescale 1ns/1ps
module tb_ap_hs_initiator;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        duft_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_rd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        stub = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_is_rd, rsp_timeout;
    logic [31:0] rsp_rdata;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] shadow [64];

    always #5 clk = ~clk;

    ap_hs_initiator_if bus();

`ifdef AP_HS_INITIATOR_STATS_EN
    logic       stat_clr = 1'b0;
    logic [1:0] stat_rd_cnt, stat_wr_cnt, stat_to_cnt;
    ap_hs_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(2)) dut (
        .clk(clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_is_rd(rsp_is_rd), .rsp_timeout(rsp_timeout),
        .stat_clr(stat_clr), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt),
        .stat_to_cnt(stat_to_cnt),
        .ap(bus)
    );
`else
    ap_hs_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_is_rd(rsp_is_rd), .rsp_timeout(rsp_timeout),
        .ap(bus)
    );
`endif

    function automatic logic [31:0] init_val(int i);
        return 32'hA500_0000 | (32'(i) * 32'h0001_0101);
    endfunction

    // DUFT responder: idle=0 during and one cycle after its reset; read -> done next cycle, write -> ack then done.
    logic [31:0] mem [64];
    logic [1:0]  r_st;
    logic        r_boot;
    logic [31:0] r_ret;
    always @(posedge clk or negedge duft_rst_n) begin
        if (!duft_rst_n) begin
            r_st   <= 2'd0;
            r_boot <= 1'b1;
            r_ret  <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else begin
            r_boot <= 1'b0;
            case (r_st)
                2'd0: if (bus.ap_start && !r_boot && !stub) begin
                    if (bus.rd_wr) begin
                        r_ret <= mem[bus.addr[5:0]];
                        r_st  <= 2'd2;
                    end else begin
                        mem[bus.addr[5:0]] <= bus.wr_data;
                        r_ret <= 32'hBAD0_BAD0;
                        r_st  <= 2'd1;
                    end
                end
                2'd1: r_st <= 2'd2;
                default: r_st <= 2'd0;
            endcase
        end
    end
    assign bus.ap_idle   = (r_st == 2'd0) && !r_boot;
    assign bus.ap_done   = (r_st == 2'd2);
    assign bus.ap_ready  = bus.ap_done;
    assign bus.ap_return = r_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns just after the accept edge.
    task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rd_wr = rd;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Counts clock edges after the accept edge until rsp_valid; stc counts cycles with ap_start high before ap_done.
    task automatic wait_rsp(output int lat, output int stc);
        lat = 0;
        stc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (bus.ap_start && !bus.ap_done && !rsp_valid) stc++;
        end while (!rsp_valid && lat < 40);
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    // Holds off rsp_ready for `stall` cycles while offering another command, then consumes the response.
    task automatic drain(input int stall, input logic [31:0] exp_rd, input logic exp_to);
        if (stall > 0) cmd_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_timeout", 32'(rsp_timeout), 32'(exp_to));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic xact(input logic rd, input logic [5:0] a, input logic [31:0] d, input int stall);
        int lat, stc;
        logic [31:0] exp_rd;
        exp_rd = rd ? shadow[a] : 32'h0;
        if (!rd) shadow[a] = d;
        rsp_ready = (stall == 0);
        send(rd, {26'h0, a}, d);
        wait_rsp(lat, stc);
        chk("latency", 32'(lat), rd ? 32'd3 : 32'd4);
        chk("start_cycles", 32'(stc), rd ? 32'd1 : 32'd2);
        chk("rdata", rsp_rdata, exp_rd);
        chk("is_rd", 32'(rsp_is_rd), 32'(rd));
        chk("timeout_flag", 32'(rsp_timeout), 32'd0);
        drain(stall, exp_rd, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, stc;
        for (int i = 0; i < 64; i++) shadow[i] = init_val(i);

        // Reset release with the responder still held in its own reset.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ap_start", 32'(bus.ap_start), 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        ap_rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        send(1'b1, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("arm_hold_start", 32'(bus.ap_start), 32'd0);
        duft_rst_n = 1'b1;
        wait_rsp(lat, stc);
        chk("arm_latency", 32'(lat), 32'd4);
        chk("arm_rdata", rsp_rdata, shadow[6'h10]);
        chk("arm_is_rd", 32'(rsp_is_rd), 32'd1);
        drain(0, shadow[6'h10], 1'b0);

        // Write then read back.
        xact(1'b0, 6'h20, 32'hDEAD_BEEF, 0);
        xact(1'b1, 6'h20, 32'h0, 0);

        // Responder never completes: timeout after TO cycles, then a normal command.
        stub = 1'b1;
        rsp_ready = 1'b1;
        send(1'b1, 32'h30, 32'h0);
        wait_rsp(lat, stc);
        chk("to_latency", 32'(lat), 32'(TO));
        chk("to_flag", 32'(rsp_timeout), 32'd1);
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_ap_start", 32'(bus.ap_start), 32'd0);
        stub = 1'b0;
        drain(0, 32'd0, 1'b1);
        xact(1'b1, 6'h30, 32'h0, 0);

        // Response back-pressure.
        xact(1'b1, 6'h05, 32'h0, 5);
        xact(1'b0, 6'h06, 32'h0BAD_F00D, 3);

        // Reset while ap_start is high: aborted write must not reach the responder.
        rsp_ready = 1'b1;
        send(1'b0, 32'h07, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        chk("busy_ap_start", 32'(bus.ap_start), 32'd1);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("async_ap_start", 32'(bus.ap_start), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        ap_rst_n = 1'b1;
        @(negedge clk);
        chk("rerst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        xact(1'b1, 6'h07, 32'h0, 0);

        // Randomized traffic against the shadow register map.
        for (int k = 0; k < 24; k++) begin
            xact(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)));
        end

`ifdef AP_HS_INITIATOR_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr_rd", 32'(stat_rd_cnt), 32'd0);
        chk("stat_clr_to", 32'(stat_to_cnt), 32'd0);
        xact(1'b0, 6'h01, 32'h5555_AAAA, 0);
        chk("stat_wr_one", 32'(stat_wr_cnt), 32'd1);
        repeat (5) xact(1'b1, 6'h01, 32'h0, 0);
        chk("stat_rd_sat", 32'(stat_rd_cnt), 32'd3);
        stat_clr = 1'b1;
        xact(1'b1, 6'h02, 32'h0, 0);
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr_prio", 32'(stat_rd_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
